// File: rtl/bcd_scan_counter_if.sv
// Control and display bus of the BCD scan counter.
// The master side drives the controls; the slave side is the counter.
interface bcd_scan_counter_if #(
   parameter int unsigned DIGITS = 2
);
   logic                  CE;
   logic                  UP;
   logic                  LOAD;
   logic [4*DIGITS-1:0]   LOAD_VAL;
   logic [4*DIGITS-1:0]   COUNT;
   logic                  CARRY;
   logic [7:0]            SEGMENTS;
   logic [DIGITS-1:0]     DIGIT_SEL;
   logic [7:0]            LED_OUT;

   modport master (
      output CE, UP, LOAD, LOAD_VAL,
      input  COUNT, CARRY, SEGMENTS, DIGIT_SEL, LED_OUT
   );

   modport slave (
      input  CE, UP, LOAD, LOAD_VAL,
      output COUNT, CARRY, SEGMENTS, DIGIT_SEL, LED_OUT
   );
endinterface

// File: rtl/bcd_scan_counter.sv
// Multi-decade up/down BCD counter with a prescaled tick, synchronous load,
// wrap carry and a time-multiplexed 7-segment drive with optional blanking.
module bcd_scan_counter #(
   parameter int unsigned DIGITS        = 2,
   parameter int unsigned PRESCALE_BITS = 15,
   parameter int unsigned SCAN_BITS     = 10,
   parameter int unsigned BLANK_LZ      = 0
) (
   input  logic               C,
   input  logic               CLR_N,
   bcd_scan_counter_if.slave  bus
);
   localparam int unsigned CW    = 4 * DIGITS;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [CW-1:0]            count_q, count_d;
   logic                     carry_q, carry_d;
   logic [PRESCALE_BITS-1:0] pre_q, pre_d;
   logic [SCAN_BITS-1:0]     scan_q, scan_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [7:0]               seg_q, seg_d;
   logic [DIGITS-1:0]        sel_q, sel_d;

   logic                     tick_c;
   logic                     all9_c, all0_c;
   logic [CW-1:0]            load_clean_c, step_c;
   logic [3:0]               dig_c, ld_c;
   logic [3:0]               cur_c;
   logic                     higher_zero_c, blank_c;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'h3F;
         4'd1:    s = 8'h06;
         4'd2:    s = 8'h5B;
         4'd3:    s = 8'h4F;
         4'd4:    s = 8'h66;
         4'd5:    s = 8'h6D;
         4'd6:    s = 8'h7D;
         4'd7:    s = 8'h07;
         4'd8:    s = 8'h7F;
         4'd9:    s = 8'h6F;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   // Ripple decade stepping: a digit steps when every lower digit is at its limit.
   always_comb begin : count_next
      load_clean_c = '0;
      step_c       = count_q;
      all9_c       = 1'b1;
      all0_c       = 1'b1;
      dig_c        = '0;
      ld_c         = '0;
      for (int i = 0; i < DIGITS; i++) begin
         dig_c = count_q[4*i +: 4];
         ld_c  = bus.LOAD_VAL[4*i +: 4];
         load_clean_c[4*i +: 4] = (ld_c > 4'd9) ? 4'd0 : ld_c;
         if (bus.UP) begin
            if (all9_c) step_c[4*i +: 4] = (dig_c == 4'd9) ? 4'd0 : 4'(dig_c + 4'd1);
         end else begin
            if (all0_c) step_c[4*i +: 4] = (dig_c == 4'd0) ? 4'd9 : 4'(dig_c - 4'd1);
         end
         all9_c = all9_c && (dig_c == 4'd9);
         all0_c = all0_c && (dig_c == 4'd0);
      end

      tick_c  = bus.CE && (pre_q == '1);
      count_d = count_q;
      carry_d = 1'b0;
      pre_d   = pre_q;
      if (bus.LOAD) begin
         count_d = load_clean_c;
         pre_d   = '0;
      end else begin
         if (bus.CE) pre_d = pre_q + PRESCALE_BITS'(1);
         if (tick_c) begin
            count_d = step_c;
            carry_d = bus.UP ? all9_c : all0_c;
         end
      end
   end

   // Scan index and the registered segment/select pair for the current digit.
   always_comb begin : display_next
      scan_d = scan_q + SCAN_BITS'(1);
      idx_d  = idx_q;
      if (scan_q == '1) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

      cur_c         = '0;
      higher_zero_c = 1'b1;
      blank_c       = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         higher_zero_c = higher_zero_c && (count_q[4*i +: 4] == 4'd0);
         if (IDX_W'(i) == idx_q) begin
            cur_c   = count_q[4*i +: 4];
            blank_c = (BLANK_LZ != 0) && (i != 0) && higher_zero_c;
         end
      end
      sel_d = DIGITS'(1) << idx_q;
      seg_d = blank_c ? 8'h00 : seg7(cur_c);
   end

   always_ff @(posedge C) begin
      if (!CLR_N) begin
         count_q <= '0;
         carry_q <= 1'b0;
         pre_q   <= '0;
         scan_q  <= '0;
         idx_q   <= '0;
         seg_q   <= '0;
         sel_q   <= '0;
      end else begin
         count_q <= count_d;
         carry_q <= carry_d;
         pre_q   <= pre_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         sel_q   <= sel_d;
      end
   end

   assign bus.COUNT     = count_q;
   assign bus.CARRY     = carry_q;
   assign bus.SEGMENTS  = seg_q;
   assign bus.DIGIT_SEL = sel_q;
   assign bus.LED_OUT   = 8'(count_q);
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: directed scenarios plus random traffic against an
// integer-valued reference model; two instances cover both blanking settings.
module tb_bcd_scan_counter;
   localparam int unsigned DIGITS        = 2;
   localparam int unsigned PRESCALE_BITS = 2;
   localparam int unsigned SCAN_BITS     = 1;
   localparam int MOD      = 100;
   localparam int PRE_MAX  = (1 << PRESCALE_BITS) - 1;
   localparam int SCAN_MAX = (1 << SCAN_BITS) - 1;

   logic       clk = 1'b0;
   logic       clr_n;
   logic       ce, up, load;
   logic [7:0] lv;

   int checks = 0;
   int errors = 0;

   // Reference model state: count kept as a plain integer value.
   int         m_cnt, m_pre, m_sdiv, m_idx;
   logic       m_carry;
   logic [7:0] m_seg0, m_seg1;
   logic [1:0] m_dsel;

   bcd_scan_counter_if #(.DIGITS(DIGITS)) bus0 ();
   bcd_scan_counter_if #(.DIGITS(DIGITS)) bus1 ();

   assign bus0.CE = ce;   assign bus0.UP = up;   assign bus0.LOAD = load;   assign bus0.LOAD_VAL = lv;
   assign bus1.CE = ce;   assign bus1.UP = up;   assign bus1.LOAD = load;   assign bus1.LOAD_VAL = lv;

   bcd_scan_counter #(.DIGITS(DIGITS), .PRESCALE_BITS(PRESCALE_BITS), .SCAN_BITS(SCAN_BITS), .BLANK_LZ(0))
      dut0 (.C(clk), .CLR_N(clr_n), .bus(bus0));
   bcd_scan_counter #(.DIGITS(DIGITS), .PRESCALE_BITS(PRESCALE_BITS), .SCAN_BITS(SCAN_BITS), .BLANK_LZ(1))
      dut1 (.C(clk), .CLR_N(clr_n), .bus(bus1));

   always #5 clk = ~clk;

   function automatic int pow10(input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r = '0;
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
      return r;
   endfunction

   function automatic logic [7:0] dec(input int d);
      case (d)
         0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
         4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
         8: return 8'h7F;  9: return 8'h6F;  default: return 8'h00;
      endcase
   endfunction

   function automatic int load_value(input logic [7:0] raw);
      int v = 0;
      int d;
      for (int i = 0; i < DIGITS; i++) begin
         d = int'((raw >> (4*i)) & 8'h0F);
         if (d > 9) d = 0;
         v += d * pow10(i);
      end
      return v;
   endfunction

   task automatic model_edge();
      int cur;
      if (!clr_n) begin
         m_cnt = 0; m_pre = 0; m_sdiv = 0; m_idx = 0;
         m_carry = 1'b0; m_seg0 = 8'h00; m_seg1 = 8'h00; m_dsel = 2'b00;
      end else begin
         cur    = (m_cnt / pow10(m_idx)) % 10;
         m_dsel = 2'(1 << m_idx);
         m_seg0 = dec(cur);
         m_seg1 = (m_idx > 0 && (m_cnt / pow10(m_idx)) == 0) ? 8'h00 : m_seg0;
         if (m_sdiv == SCAN_MAX) begin
            m_sdiv = 0;
            m_idx  = (m_idx + 1) % DIGITS;
         end else begin
            m_sdiv++;
         end
         if (load) begin
            m_cnt = load_value(lv); m_pre = 0; m_carry = 1'b0;
         end else if (ce && m_pre == PRE_MAX) begin
            m_pre = 0;
            if (up) begin m_carry = (m_cnt == MOD - 1); m_cnt = (m_cnt + 1) % MOD; end
            else    begin m_carry = (m_cnt == 0);       m_cnt = (m_cnt + MOD - 1) % MOD; end
         end else begin
            if (ce) m_pre++;
            m_carry = 1'b0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("count",  32'(bus0.COUNT),     32'(to_bcd(m_cnt)));
      check("count1", 32'(bus1.COUNT),     32'(to_bcd(m_cnt)));
      check("carry",  32'(bus0.CARRY),     32'(m_carry));
      check("led",    32'(bus0.LED_OUT),   32'(to_bcd(m_cnt)));
      check("dsel0",  32'(bus0.DIGIT_SEL), 32'(m_dsel));
      check("dsel1",  32'(bus1.DIGIT_SEL), 32'(m_dsel));
      check("seg0",   32'(bus0.SEGMENTS),  32'(m_seg0));
      check("seg1",   32'(bus1.SEGMENTS),  32'(m_seg1));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1; lv = v;
      step();
      load = 1'b0;
   endtask

   initial begin
      clr_n = 1'b0; ce = 1'b0; up = 1'b1; load = 1'b0; lv = 8'h00;
      m_cnt = 0; m_pre = 0; m_sdiv = 0; m_idx = 0;
      m_carry = 1'b0; m_seg0 = '0; m_seg1 = '0; m_dsel = '0;
      steps(3);
      check("rst_count", 32'(bus0.COUNT), 32'h00);
      check("rst_dsel",  32'(bus0.DIGIT_SEL), 32'h0);

      // Reset release and first ticks
      #1 clr_n = 1'b1; ce = 1'b1; up = 1'b1;
      step();
      check("first_dsel", 32'(bus0.DIGIT_SEL), 32'h1);
      check("first_seg",  32'(bus0.SEGMENTS),  32'h3F);
      steps(2);
      check("pre_tick", 32'(bus0.COUNT), 32'h00);
      step();
      check("tick4", 32'(bus0.COUNT), 32'h01);
      steps(36);
      check("tick40", 32'(bus0.COUNT), 32'h10);

      // Up wrap
      up = 1'b1;
      do_load(8'h98);
      steps(4);
      check("up_99", 32'(bus0.COUNT), 32'h99);
      steps(3);
      check("up_nocarry", 32'(bus0.CARRY), 32'h0);
      step();
      check("up_wrap", 32'(bus0.COUNT), 32'h00);
      check("up_carry", 32'(bus0.CARRY), 32'h1);
      step();
      check("up_carry_end", 32'(bus0.CARRY), 32'h0);

      // Down wrap
      up = 1'b0;
      do_load(8'h01);
      steps(4);
      check("dn_00", 32'(bus0.COUNT), 32'h00);
      steps(4);
      check("dn_99", 32'(bus0.COUNT), 32'h99);
      check("dn_carry", 32'(bus0.CARRY), 32'h1);
      step();
      check("dn_carry_end", 32'(bus0.CARRY), 32'h0);
      steps(3);
      check("dn_98", 32'(bus0.COUNT), 32'h98);

      // Load rules
      up = 1'b1;
      do_load(8'hA7);
      check("load_a7", 32'(bus0.COUNT), 32'h07);
      steps(3);
      do_load(8'h42);
      check("load_on_tick", 32'(bus0.COUNT), 32'h42);
      check("load_on_tick_carry", 32'(bus0.CARRY), 32'h0);
      ce = 1'b0;
      do_load(8'h33);
      check("load_ce0", 32'(bus0.COUNT), 32'h33);
      steps(10);
      check("freeze", 32'(bus0.COUNT), 32'h33);
      ce = 1'b1; steps(2);
      ce = 1'b0; steps(10);
      ce = 1'b1; step();
      check("phase_hold", 32'(bus0.COUNT), 32'h33);
      step();
      check("phase_resume", 32'(bus0.COUNT), 32'h34);

      // Scan and blanking
      ce = 1'b0;
      do_load(8'h05);
      step();
      for (int i = 0; i < 8; i++) begin
         step();
         if (m_dsel == 2'b01) begin
            check("scan_d0_seg0", 32'(bus0.SEGMENTS), 32'h6D);
            check("scan_d0_seg1", 32'(bus1.SEGMENTS), 32'h6D);
         end else begin
            check("scan_d1_seg0", 32'(bus0.SEGMENTS), 32'h3F);
            check("scan_d1_seg1", 32'(bus1.SEGMENTS), 32'h00);
         end
      end

      // Reset on the carry cycle
      ce = 1'b1; up = 1'b1;
      do_load(8'h99);
      steps(4);
      check("pre_rst_carry", 32'(bus0.CARRY), 32'h1);
      clr_n = 1'b0;
      step();
      check("mid_rst_count", 32'(bus0.COUNT),     32'h00);
      check("mid_rst_carry", 32'(bus0.CARRY),     32'h0);
      check("mid_rst_seg",   32'(bus0.SEGMENTS),  32'h00);
      check("mid_rst_dsel",  32'(bus0.DIGIT_SEL), 32'h0);
      check("mid_rst_led",   32'(bus0.LED_OUT),   32'h00);
      clr_n = 1'b1;
      step();
      check("post_rst_dsel", 32'(bus0.DIGIT_SEL), 32'h1);
      check("post_rst_seg",  32'(bus0.SEGMENTS),  32'h3F);

      // Random traffic
      do_load(8'h97);
      for (int i = 0; i < 600; i++) begin
         clr_n = ($urandom_range(0, 99) != 0);
         ce    = ($urandom_range(0, 3) != 0);
         up    = 1'($urandom_range(0, 1));
         load  = ($urandom_range(0, 19) == 0);
         lv    = 8'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Parametrised multi-digit BCD event counter with integrated multiplexed 7-segment drive. It is the successor to the two-digit prescaled demo counter on the XC9572 board. It adds:
- `DIGITS` decades
- up/down counting
- synchronous load
- a wrap carry
- a one-bus time-multiplexed display output with optional leading-zero blanking

It sits between the board clock/switch inputs and the LED/7-segment connectors.

## Interface
Parameters:
- `DIGITS`, 2, number of BCD decades (1..8)
- `PRESCALE_BITS`, 15, prescaler width; one count tick per 2^`PRESCALE_BITS` enabled clocks (1..24)
- `SCAN_BITS`, 10, display scan divider; digit select advances every 2^`SCAN_BITS` clocks (1..20)
- `BLANK_LZ`, 0, 1 = blank leading zero digits

Ports:
- `C`  in  1  clock, all logic on rising edge
- `CLR_N`  in  1  reset, synchronous, active-low
- `CE`  in  1  count enable; gates the prescaler
- `UP`  in  1  direction: 1 = up, 0 = down
- `LOAD`  in  1  synchronous load strobe
- `LOAD_VAL`  in  4*`DIGITS`  BCD load value, digit 0 in [3:0]
- `COUNT`  out  4*`DIGITS`  current BCD count, digit 0 in [3:0]
- `CARRY`  out  1  one-cycle pulse on full-range wrap (up or down)
- `SEGMENTS`  out  8  pattern of the selected digit, bit order Dgfedcba, active high
- `DIGIT_SEL`  out  `DIGITS`  one-hot digit enable, active high
- `LED_OUT`  out  8  `COUNT[7:0]`, zero-extended if `DIGITS`=1

## Operation
- **Reset.** While `CLR_N`=0 at a rising edge, the following are cleared to 0:
  - `COUNT`, `CARRY`, the prescaler, the scan divider, the scan index, `SEGMENTS` (0x00) and `DIGIT_SEL`.
- **Priority.** `CLR_N` low, then `LOAD`, then count tick.
- **Prescaler.**
  - Increments on each edge with `CE`=1 and holds when `CE`=0.
  - `tick` = `CE` & (prescaler == all ones). The count steps on that same edge, and the prescaler wraps to 0.
- **Up count.**
  - Digit 0 steps +1.
  - Digit i steps when all lower digits equal 9.
  - A digit at 9 that steps becomes 0.
- **Down count.**
  - Digit 0 steps −1.
  - Digit i steps when all lower digits equal 0.
  - A digit at 0 that steps becomes 9.
- **CARRY.**
  - Asserted for exactly one cycle after an up tick from all-9 to all-0, or a down tick from all-0 to all-9.
  - Otherwise 0.
- **LOAD.**
  - `COUNT` ← `LOAD_VAL` and the prescaler ← 0, independent of `CE`.
  - `CARRY` = 0.
  - Any `LOAD_VAL` digit > 9 is loaded as 0.
- **UP.** May change at any cycle and takes effect on the next tick.
- **Scan.**
  - The divider is free-running and not gated by `CE`.
  - When it wraps, the index advances 0..`DIGITS`-1 and wraps to 0.
- **Display output.**
  - Registered: `DIGIT_SEL` = one-hot(index) and `SEGMENTS` = decode(`COUNT` digit[index]).
  - Both are sampled from the pre-edge values, giving 1 cycle of latency.
- **Decode (hex).**
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Codes A–F give 00.
  - Bit 7 (DP) is always 0.
- **Blanking (`BLANK_LZ`=1).**
  - A digit i>0 is blanked (`SEGMENTS`=00, `DIGIT_SEL` still driven) when it and all higher digits are 0.
  - Digit 0 is never blanked.

## Timing
- Count latency: `COUNT` updates on the tick edge and is visible in the following cycle. `CARRY` is visible in the same cycle.
- `CE` low mid-period freezes the prescaler phase. When `CE` returns, counting resumes from the frozen phase.
- A `LOAD` and a tick on the same edge: `LOAD` wins, with no step and no `CARRY`.
- Reset asserted mid-operation clears everything on that edge, including a pending `CARRY`.
- First edge after `CLR_N` rises: `DIGIT_SEL` = ...001, `SEGMENTS` = 3F.
- `SEGMENTS`/`DIGIT_SEL` change only together, on one edge, so there is no cross-digit glitch.
- The reset-to-first-tick interval with `CE`=1 is exactly 2^`PRESCALE_BITS` edges.

## Test plan
Bench configuration: `DIGITS`=2, `PRESCALE_BITS`=2, `SCAN_BITS`=1.
1. **Reset and first tick.** Reset, then `CE`=1, `UP`=1 → `COUNT` = 0x01 after 4 edges and 0x10 after 40 edges. `CARRY` stays 0.
2. **Up wrap.** `LOAD` 0x98, `UP`=1 → next tick gives 0x99; the following tick gives 0x00 with `CARRY`=1 for exactly one cycle.
3. **Down wrap.** `LOAD` 0x01, `UP`=0 → ticks give 0x00, then 0x99 with `CARRY` pulse, then 0x98.
4. **Load rules.**
   - `LOAD_VAL`=0xA7 → `COUNT`=0x07.
   - `LOAD` asserted on a tick edge → no step.
   - `LOAD` with `CE`=0 → still loads.
   - `CE`=0 for 10 cycles → `COUNT` and prescaler frozen.
5. **Scan and blanking.** `COUNT`=0x05:
   - `DIGIT_SEL` alternates 01/10 every 2 cycles.
   - `SEGMENTS` = 6D on 01.
   - On 10: `SEGMENTS` = 3F with `BLANK_LZ`=0, and 00 with `BLANK_LZ`=1.
6. **Reset mid-operation.** Pull `CLR_N` low on the `CARRY` cycle → next cycle all outputs are 0. `LED_OUT` tracks `COUNT[7:0]` throughout.
